// File: rtl/ifu_pkg.sv
// IFU shared definitions: widths, reset PC and FSM state encoding.
// Exports IFU_XLEN, IFU_ILEN, IFU_RESET_PC, ifu_state_e and pc_aligned().
package ifu_pkg;

  localparam int IFU_XLEN = 64;
  localparam int IFU_ILEN = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ifu_state_e;

  function automatic logic pc_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry registered FIFO used as the fetch instruction buffer.
// Ports: i_clk, i_rst, i_flush, i_push/i_data, i_pop -> o_data (head), o_valid, o_count.
module ifu_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // push into a full buffer is only legal when the head leaves this cycle
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = r_count != 2'd0;
  assign o_count = r_count;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues word fetches, buffers responses, handles redirects.
// Ports: clk/rst, imem_req_* / imem_rsp_* memory side, redirect_*, if_* / instr_o / pc_o decoder side.
module ifu
  import ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            if_fetch_err_o,
  output logic            if_misalign_o
);

  localparam int EW = IFU_ILEN + XLEN + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  ifu_state_e      r_state;
  ifu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [1:0]      r_inflight;
  logic [1:0]      r_drop_cnt;
  logic [1:0]      w_buf_count;
  logic            w_buf_valid;
  logic [2:0]      w_credit;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;

  assign w_credit = {1'b0, r_inflight} + {1'b0, w_buf_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = pc_aligned(redirect_pc_i[1:0]) ? ST_RUN : ST_HALT;
    end else if (r_state == ST_BOOT) begin
      w_state_nxt = ST_RUN;
    end
  end

  // outstanding requests plus buffered entries never exceed the buffer depth
  always_comb begin
    imem_req_valid_o = 1'b0;
    if_misalign_o    = 1'b0;
    unique case (r_state)
      ST_RUN:  imem_req_valid_o = (w_credit < 3'd2) && !redirect_i;
      ST_HALT: if_misalign_o = 1'b1;
      default: ;
    endcase
  end

  assign w_req_fire = imem_req_valid_o && imem_req_ready_i;
  assign w_rsp_keep = imem_rsp_valid_i && !redirect_i && (r_drop_cnt == 2'd0);
  assign w_pop      = w_buf_valid && if_ready_i && !redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else begin
      r_inflight <= r_inflight + {1'b0, w_req_fire}
                  - {1'b0, imem_rsp_valid_i};
      if (redirect_i) begin
        r_fetch_pc <= redirect_pc_i;
        r_resp_pc  <= redirect_pc_i;
        // everything still outstanding after this cycle's response is stale
        r_drop_cnt <= r_inflight - {1'b0, imem_rsp_valid_i};
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_rsp_keep) r_resp_pc <= r_resp_pc + PC_STEP;
        if (imem_rsp_valid_i && (r_drop_cnt != 2'd0)) begin
          r_drop_cnt <= r_drop_cnt - 2'd1;
        end
      end
    end
  end

  assign w_push_data = {imem_rsp_data_i, r_resp_pc, imem_rsp_err_i};

  ifu_fifo #(
    .W(EW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (redirect_i),
    .i_push  (w_rsp_keep),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_buf_valid),
    .o_count (w_buf_count)
  );

  assign imem_req_addr_o = r_fetch_pc;
  assign if_valid_o      = w_buf_valid;
  assign instr_o         = w_head[EW-1 -: IFU_ILEN];
  assign pc_o            = w_head[XLEN:1];
  assign if_fetch_err_o  = w_head[0];

endmodule
